// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among execution units, with an
// optional one-entry output spill register and a contention counter.

module cdb_eu_slot (
    input  logic sel,
    input  logic valid,
    input  logic take,
    output logic ready,
    output logic stall
);
    assign ready = sel & take;
    assign stall = valid & ~ready;
endmodule

module cdb_arbiter #(
    parameter int EU_N       = 7,
    parameter int PAY_W      = 76,
    parameter int SPILL_SKIP = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic [EU_N-1:0]       eu_valid_i,
    output logic [EU_N-1:0]       eu_ready_o,
    input  logic [EU_N*PAY_W-1:0] eu_data_i,
    output logic                  cdb_valid_o,
    input  logic                  cdb_ready_i,
    output logic [PAY_W-1:0]      cdb_data_o,
    output logic [2:0]            cdb_src_o,
    output logic [CNT_W-1:0]      cdb_stall_cnt_o
);
    localparam int SRC_W = 3;

    typedef enum logic {EMPTY, FULL} spill_e;

    logic [SRC_W-1:0] prio_q;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [EU_N-1:0]  gnt_oh;
    logic [PAY_W-1:0] gnt_data;
    logic             take;
    logic             xfer;
    logic [EU_N-1:0]  stall_vec;

    // Scan from prio upward with wrap; first valid unit wins.
    always_comb begin
        int j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < EU_N; k++) begin
            j = int'(prio_q) + k;
            if (j >= EU_N) j = j - EU_N;
            if (!gnt_vld && eu_valid_i[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(j);
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        gnt_data = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
            gnt_data        = eu_data_i[int'(gnt_idx)*PAY_W +: PAY_W];
        end
    end

    genvar i;
    generate
        for (i = 0; i < EU_N; i++) begin : g_slot
            cdb_eu_slot u_slot (
                .sel   (gnt_oh[i]),
                .valid (eu_valid_i[i]),
                .take  (take),
                .ready (eu_ready_o[i]),
                .stall (stall_vec[i])
            );
        end
    endgenerate

    assign xfer = gnt_vld & take;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q <= '0;
        end else if (xfer) begin
            prio_q <= (gnt_idx == SRC_W'(EU_N-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Flush cycles are excluded from contention accounting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cdb_stall_cnt_o <= '0;
        end else if (!flush_i && |stall_vec) begin
            cdb_stall_cnt_o <= cdb_stall_cnt_o + 1'b1;
        end
    end

    generate
        if (SPILL_SKIP != 0) begin : g_skip
            // Outputs are forced low while reset is held, not just after the edge.
            assign take        = cdb_ready_i & ~flush_i & rst_n_i;
            assign cdb_valid_o = (|eu_valid_i) & ~flush_i & rst_n_i;
            assign cdb_data_o  = rst_n_i ? gnt_data : '0;
            assign cdb_src_o   = (rst_n_i && gnt_vld) ? gnt_idx : '0;
        end else begin : g_spill
            spill_e           state_q, state_d;
            logic [PAY_W-1:0] data_q;
            logic [SRC_W-1:0] src_q;
            logic             can_load;

            assign can_load = (state_q == EMPTY) | cdb_ready_i;
            assign take     = can_load & ~flush_i & rst_n_i;

            always_comb begin
                state_d = state_q;
                if (flush_i) begin
                    state_d = EMPTY;
                end else if (xfer) begin
                    state_d = FULL;
                end else if (state_q == FULL && cdb_ready_i) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    state_q <= EMPTY;
                    data_q  <= '0;
                    src_q   <= '0;
                end else begin
                    state_q <= state_d;
                    if (xfer) begin
                        data_q <= gnt_data;
                        src_q  <= gnt_idx;
                    end
                end
            end

            assign cdb_valid_o = (state_q == FULL);
            assign cdb_data_o  = (state_q == FULL) ? data_q : '0;
            assign cdb_src_o   = (state_q == FULL) ? src_q : '0;
        end
    endgenerate
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the Common Data Bus (CDB) among the execution units: load buffer, store buffer, branch unit, ALU, MULT, DIV and FPU.
- Each cycle, at most one unit's result packet is forwarded to the ROB and the reservation stations.
- Round-robin arbitration, with an optional one-entry output spill register.
- Exports a contention counter for the HPM CSRs.

Parameters:
- EU_N, 7, number of requesting execution units (equals MAX_EU_N).
- PAY_W, 76, width of one result packet: ROB index (5) + value (64) + except flag (1) + except code (6).
- SPILL_SKIP, 1, 1 = combinational path from the selected unit to the CDB; 0 = one-entry output register.
- CNT_W, 32, width of the contention counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush (mispredict/exception), synchronous
- eu_valid_i  in  EU_N  unit i presents a result
- eu_ready_o  out  EU_N  result of unit i accepted this cycle
- eu_data_i  in  EU_N*PAY_W  packets, unit i at bits [i*PAY_W +: PAY_W]
- cdb_valid_o  out  1  CDB packet valid
- cdb_ready_i  in  1  ROB/CDB consumer ready
- cdb_data_o  out  PAY_W  CDB packet
- cdb_src_o  out  3  index of the unit owning the current CDB packet
- cdb_stall_cnt_o  out  CNT_W  cycles with at least one valid unit not accepted

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - prio pointer = 0; spill register valid = 0; cdb_stall_cnt_o = 0.
  - All outputs are 0: eu_ready_o=0, cdb_valid_o=0, cdb_data_o=0, cdb_src_o=0.
- Grant selection (combinational):
  - g = first index i with eu_valid_i[i]=1, scanning prio, prio+1, …, EU_N-1, 0, …, prio-1.
  - No valid requester → no grant.
  - At most one bit of eu_ready_o is set, and only bit g.
- Round-robin update: on an accepted transfer (eu_valid_i[g] & eu_ready_o[g]), prio <= (g+1) mod EU_N at the next edge. With g=EU_N-1, prio wraps to 0. With no transfer, prio holds.
- SPILL_SKIP=1:
  - cdb_valid_o = |eu_valid_i.
  - cdb_data_o = packet g; cdb_src_o = g.
  - eu_ready_o[g] = cdb_ready_i.
  - Zero latency.
  - With no grant, cdb_data_o = 0 and cdb_src_o = 0.
- SPILL_SKIP=0:
  - Register states: EMPTY, FULL.
  - can_load = EMPTY | (FULL & cdb_ready_i).
  - eu_ready_o[g] = can_load.
  - Accepted packet is registered and appears on cdb_* the following cycle, so latency is 1.
  - FULL & cdb_ready_i & new accept → reload in the same cycle (full throughput, no bubble).
  - FULL & cdb_ready_i & no accept → EMPTY.
  - FULL & !cdb_ready_i → hold cdb_data_o and cdb_src_o stable.
  - cdb_valid_o = FULL.
- Flush (flush_i=1):
  - eu_ready_o = 0 for that cycle; no packet is accepted.
  - Spill register cleared to EMPTY at the next edge, so cdb_valid_o=0 the next cycle.
  - In SPILL_SKIP=1, cdb_valid_o is forced to 0 during the flush cycle.
  - prio is not modified.
  - cdb_stall_cnt_o does not count flush cycles.
- Contention counter:
  - Increments by 1 in a cycle where !flush_i and (|(eu_valid_i & ~eu_ready_o)) = 1.
  - Wraps modulo 2^CNT_W; it does not saturate.
  - Cleared only by reset.
- Handshake rules:
  - A unit holds eu_valid_i and its packet stable until accepted; the arbiter does not depend on this for correctness.
  - A unit deasserting valid before acceptance is legal; that unit is dropped from the scan that cycle.

Test Plan:
- Reset mid-operation: SPILL_SKIP=0, register FULL holding unit 4 packet, assert rst_n_i=0 asynchronously → cdb_valid_o=0 immediately. After release with units 0 and 4 valid and cdb_ready_i=1 → unit 0 wins first (prio=0).
- Round-robin fairness: SPILL_SKIP=1, cdb_ready_i=1, eu_valid_i=7'b1111111 for 7 cycles → cdb_src_o sequence 0,1,2,3,4,5,6, then 0. cdb_stall_cnt_o=7 after 7 cycles.
- Wrap and skip: prio=5, eu_valid_i=7'b0001010 (units 1 and 3) → grant 1, then prio=2 → grant 3, then prio=4.
- Backpressure with spill: SPILL_SKIP=0, unit 2 sends packet with value 64'hDEAD_BEEF and ROB idx 9, cdb_ready_i=0 for 3 cycles → cdb_data_o stable and eu_ready_o=0 throughout. Then cdb_ready_i=1 with unit 6 valid → unit 6 loaded the same cycle, no bubble.
- Flush: register FULL, units 0 and 3 valid, flush_i=1 for 1 cycle → eu_ready_o=0 that cycle, cdb_valid_o=0 next cycle, counter unchanged, prio unchanged.
- Counter wrap: CNT_W=4, hold 2 valid units with cdb_ready_i=0 for 17 cycles → cdb_stall_cnt_o=1.
